// File: rtl/operand_issue_ctrl.sv
// Operand-fetch/issue front end: stage A presents indices to the hazard unit and RF,
// stage B resolves operands from forwarding or sampled RF data and issues to EX.
module operand_issue_ctrl #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_instr,
  input  logic [XLEN-1:0]  dec_pc,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic [XLEN-1:0]  dec_imm,
  output logic [4:0]       rf_rs1_addr,
  output logic [4:0]       rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  output logic             of_valid,
  output logic [4:0]       of_rs1,
  output logic [4:0]       of_rs2,
  output logic [4:0]       of_rd,
  input  logic             fwd_rs1_enable,
  input  logic             fwd_rs2_enable,
  input  logic [XLEN-1:0]  fwd_rs1_data,
  input  logic [XLEN-1:0]  fwd_rs2_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [CNT_W-1:0] stall_count
);

  logic            a_valid_q, a_valid_d;
  logic [31:0]     a_instr_q, a_instr_d;
  logic [XLEN-1:0] a_pc_q, a_pc_d, a_imm_q, a_imm_d;
  logic [4:0]      a_rs1_q, a_rs1_d, a_rs2_q, a_rs2_d, a_rd_q, a_rd_d;

  logic            b_valid_q, b_valid_d;
  logic [31:0]     b_instr_q, b_instr_d;
  logic [XLEN-1:0] b_pc_q, b_pc_d, b_imm_q, b_imm_d;
  logic [4:0]      b_rs1_q, b_rs1_d, b_rs2_q, b_rs2_d, b_rd_q, b_rd_d;
  logic [XLEN-1:0] b_rf1_q, b_rf1_d, b_rf2_q, b_rf2_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hold;
  logic transfer;

  assign hold      = stall & a_valid_q;
  assign dec_ready = ~flush & (~stall | ~a_valid_q);
  assign transfer  = dec_valid & dec_ready;

  always_comb begin
    a_valid_d   = a_valid_q;
    a_instr_d   = a_instr_q;
    a_pc_d      = a_pc_q;
    a_imm_d     = a_imm_q;
    a_rs1_d     = a_rs1_q;
    a_rs2_d     = a_rs2_q;
    a_rd_d      = a_rd_q;
    b_valid_d   = b_valid_q;
    b_instr_d   = b_instr_q;
    b_pc_d      = b_pc_q;
    b_imm_d     = b_imm_q;
    b_rs1_d     = b_rs1_q;
    b_rs2_d     = b_rs2_q;
    b_rd_d      = b_rd_q;
    b_rf1_d     = b_rf1_q;
    b_rf2_d     = b_rf2_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (hold) begin
        b_valid_d = 1'b0;
      end else begin
        b_valid_d = a_valid_q;
        b_instr_d = a_instr_q;
        b_pc_d    = a_pc_q;
        b_imm_d   = a_imm_q;
        b_rs1_d   = a_rs1_q;
        b_rs2_d   = a_rs2_q;
        b_rd_d    = a_rd_q;
        b_rf1_d   = rf_rs1_data;
        b_rf2_d   = rf_rs2_data;
      end

      // Unused sources are zeroed so the hazard unit never sees a false dependency.
      if (transfer) begin
        a_valid_d = 1'b1;
        a_instr_d = dec_instr;
        a_pc_d    = dec_pc;
        a_imm_d   = dec_imm;
        a_rs1_d   = dec_uses_rs1 ? dec_rs1 : 5'd0;
        a_rs2_d   = dec_uses_rs2 ? dec_rs2 : 5'd0;
        a_rd_d    = dec_rd;
      end else if (!hold) begin
        a_valid_d = 1'b0;
      end

      if (hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_instr_q   <= '0;
      a_pc_q      <= '0;
      a_imm_q     <= '0;
      a_rs1_q     <= '0;
      a_rs2_q     <= '0;
      a_rd_q      <= '0;
      b_valid_q   <= 1'b0;
      b_instr_q   <= '0;
      b_pc_q      <= '0;
      b_imm_q     <= '0;
      b_rs1_q     <= '0;
      b_rs2_q     <= '0;
      b_rd_q      <= '0;
      b_rf1_q     <= '0;
      b_rf2_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_instr_q   <= a_instr_d;
      a_pc_q      <= a_pc_d;
      a_imm_q     <= a_imm_d;
      a_rs1_q     <= a_rs1_d;
      a_rs2_q     <= a_rs2_d;
      a_rd_q      <= a_rd_d;
      b_valid_q   <= b_valid_d;
      b_instr_q   <= b_instr_d;
      b_pc_q      <= b_pc_d;
      b_imm_q     <= b_imm_d;
      b_rs1_q     <= b_rs1_d;
      b_rs2_q     <= b_rs2_d;
      b_rd_q      <= b_rd_d;
      b_rf1_q     <= b_rf1_d;
      b_rf2_q     <= b_rf2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign of_valid    = a_valid_q;
  assign of_rs1      = a_rs1_q;
  assign of_rs2      = a_rs2_q;
  assign of_rd       = a_rd_q;
  assign rf_rs1_addr = a_rs1_q;
  assign rf_rs2_addr = a_rs2_q;

  // x0 reads zero even when the hazard unit asserts forwarding for it.
  assign ex_valid   = b_valid_q;
  assign ex_instr   = b_valid_q ? b_instr_q : NOP_INSTR;
  assign ex_pc      = b_valid_q ? b_pc_q : '0;
  assign ex_imm     = b_valid_q ? b_imm_q : '0;
  assign ex_rd      = b_valid_q ? b_rd_q : 5'd0;
  assign ex_rs1_val = (!b_valid_q || b_rs1_q == 5'd0) ? '0 :
                      fwd_rs1_enable ? fwd_rs1_data : b_rf1_q;
  assign ex_rs2_val = (!b_valid_q || b_rs2_q == 5'd0) ? '0 :
                      fwd_rs2_enable ? fwd_rs2_data : b_rf2_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Bench for operand_issue_ctrl: directed scenarios plus random traffic checked against
// an instruction-slot reference model; a second CNT_W=4 instance exercises saturation.
module tb_operand_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        reset, flush, stall, dvalid;
    logic [31:0] instr, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic        fe1, fe2;
    logic [31:0] fd1, fd2;
  } stim_t;

  typedef struct {
    bit          valid;
    logic [31:0] instr, pc, imm;
    logic [4:0]  rs1, rs2, rd;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, stall, dec_valid;
  logic [31:0] dec_instr, dec_pc, dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_uses_rs1, dec_uses_rs2;
  logic        fwd_rs1_enable, fwd_rs2_enable;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;

  logic        dec_ready, of_valid, ex_valid;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, of_rs1, of_rs2, of_rd, ex_rd;
  logic [31:0] rf_rs1_data, rf_rs2_data, ex_instr, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [15:0] stall_count;

  logic        dec_ready4, of_valid4, ex_valid4;
  logic [4:0]  rf_rs1_addr4, rf_rs2_addr4, of_rs1_4, of_rs2_4, of_rd4, ex_rd4;
  logic [31:0] rf_rs1_data4, rf_rs2_data4, ex_instr4, ex_pc4, ex_imm4, ex_rs1_val4, ex_rs2_val4;
  logic [3:0]  stall_count4;

  logic [31:0] rfMem [32];
  assign rf_rs1_data  = rfMem[rf_rs1_addr];
  assign rf_rs2_data  = rfMem[rf_rs2_addr];
  assign rf_rs1_data4 = rfMem[rf_rs1_addr4];
  assign rf_rs2_data4 = rfMem[rf_rs2_addr4];

  operand_issue_ctrl dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_imm(dec_imm), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .of_valid(of_valid),
    .of_rs1(of_rs1), .of_rs2(of_rs2), .of_rd(of_rd),
    .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs2_enable(fwd_rs2_enable),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .stall_count(stall_count)
  );

  operand_issue_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready4),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_imm(dec_imm), .rf_rs1_addr(rf_rs1_addr4), .rf_rs2_addr(rf_rs2_addr4),
    .rf_rs1_data(rf_rs1_data4), .rf_rs2_data(rf_rs2_data4), .of_valid(of_valid4),
    .of_rs1(of_rs1_4), .of_rs2(of_rs2_4), .of_rd(of_rd4),
    .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs2_enable(fwd_rs2_enable),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .stall(stall), .flush(flush), .ex_valid(ex_valid4), .ex_instr(ex_instr4),
    .ex_pc(ex_pc4), .ex_imm(ex_imm4), .ex_rd(ex_rd4), .ex_rs1_val(ex_rs1_val4),
    .ex_rs2_val(ex_rs2_val4), .stall_count(stall_count4)
  );

  int    compared   = 0;
  int    mismatched = 0;
  slot_t mA, mB;
  int    stallCnt   = 0;
  bit    modelInit  = 0;
  bit    justReset  = 0;
  stim_t cur;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expOperand(input slot_t s, input logic [4:0] rs,
                                             input logic fe, input logic [31:0] fd);
    if (!s.valid || rs == 5'd0) return 32'd0;
    return fe ? fd : rfMem[rs];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, flush: 1'b0, stall: 1'b0, dvalid: 1'b0, instr: 32'd0, pc: 32'd0,
          imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0,
          fe1: 1'b0, fe2: 1'b0, fd1: 32'd0, fd2: 32'd0};
    return s;
  endfunction

  function automatic stim_t instrStim(input logic [31:0] instr, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic u1, input logic u2);
    stim_t s;
    s        = idle();
    s.dvalid = 1'b1;
    s.instr  = instr;
    s.pc     = 32'h1000 + {instr[15:0], 2'b00};
    s.imm    = ~instr;
    s.rs1    = rs1;
    s.rs2    = rs2;
    s.rd     = rd;
    s.u1     = u1;
    s.u2     = u2;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s        = instrStim($urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                         5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
    s.dvalid = ($urandom_range(0, 9) < 7);
    s.stall  = ($urandom_range(0, 3) == 0);
    s.flush  = ($urandom_range(0, 19) == 0);
    s.reset  = ($urandom_range(0, 99) == 0);
    s.fe1    = 1'($urandom_range(0, 1));
    s.fe2    = 1'($urandom_range(0, 1));
    s.fd1    = $urandom;
    s.fd2    = $urandom;
    return s;
  endfunction

  // Drive one cycle's inputs after the falling edge, then compare against the model.
  task automatic applyStimulus(input stim_t s);
    logic expReady;
    int   e16, e4;
    @(negedge clk);
    cur            = s;
    reset          = s.reset;
    flush          = s.flush;
    stall          = s.stall;
    dec_valid      = s.dvalid;
    dec_instr      = s.instr;
    dec_pc         = s.pc;
    dec_imm        = s.imm;
    dec_rs1        = s.rs1;
    dec_rs2        = s.rs2;
    dec_rd         = s.rd;
    dec_uses_rs1   = s.u1;
    dec_uses_rs2   = s.u2;
    fwd_rs1_enable = s.fe1;
    fwd_rs2_enable = s.fe2;
    fwd_rs1_data   = s.fd1;
    fwd_rs2_data   = s.fd2;
    #1;
    if (modelInit) begin
      expReady = !s.flush && (!s.stall || !mA.valid);
      checkOutput("dec_ready", 32'(dec_ready), 32'(expReady));
      checkOutput("of_valid", 32'(of_valid), 32'(mA.valid));
      if (mA.valid) begin
        checkOutput("of_rs1", 32'(of_rs1), 32'(mA.rs1));
        checkOutput("of_rs2", 32'(of_rs2), 32'(mA.rs2));
        checkOutput("of_rd", 32'(of_rd), 32'(mA.rd));
        checkOutput("rf_rs1_addr", 32'(rf_rs1_addr), 32'(mA.rs1));
        checkOutput("rf_rs2_addr", 32'(rf_rs2_addr), 32'(mA.rs2));
      end
      if (justReset) begin
        checkOutput("rst_of_rs1", 32'(of_rs1), 32'd0);
        checkOutput("rst_of_rs2", 32'(of_rs2), 32'd0);
        checkOutput("rst_of_rd", 32'(of_rd), 32'd0);
        checkOutput("rst_ex_pc", ex_pc, 32'd0);
        checkOutput("rst_ex_imm", ex_imm, 32'd0);
      end
      checkOutput("ex_valid", 32'(ex_valid), 32'(mB.valid));
      checkOutput("ex_instr", ex_instr, mB.valid ? mB.instr : NOP);
      checkOutput("ex_rd", 32'(ex_rd), mB.valid ? 32'(mB.rd) : 32'd0);
      checkOutput("ex_rs1_val", ex_rs1_val, expOperand(mB, mB.rs1, s.fe1, s.fd1));
      checkOutput("ex_rs2_val", ex_rs2_val, expOperand(mB, mB.rs2, s.fe2, s.fd2));
      if (mB.valid) begin
        checkOutput("ex_pc", ex_pc, mB.pc);
        checkOutput("ex_imm", ex_imm, mB.imm);
      end
      e16 = (stallCnt > 65535) ? 65535 : stallCnt;
      e4  = (stallCnt > 15) ? 15 : stallCnt;
      checkOutput("stall_count", 32'(stall_count), 32'(e16));
      checkOutput("stall_count4", 32'(stall_count4), 32'(e4));
    end
  endtask

  // Advance the reference model across the rising edge using the driven inputs.
  task automatic stepClock();
    bit    hold, ready;
    slot_t nB;
    @(posedge clk);
    if (cur.reset) begin
      mA.valid  = 0;
      mB.valid  = 0;
      stallCnt  = 0;
      modelInit = 1;
      justReset = 1;
    end else begin
      justReset = 0;
      hold      = cur.stall && mA.valid;
      ready     = !cur.flush && (!cur.stall || !mA.valid);
      if (cur.flush) begin
        mA.valid = 0;
        mB.valid = 0;
      end else begin
        nB = mA;
        if (hold) nB.valid = 0;
        if (cur.dvalid && ready) begin
          mA.valid = 1;
          mA.instr = cur.instr;
          mA.pc    = cur.pc;
          mA.imm   = cur.imm;
          mA.rs1   = cur.u1 ? cur.rs1 : 5'd0;
          mA.rs2   = cur.u2 ? cur.rs2 : 5'd0;
          mA.rd    = cur.rd;
        end else if (!hold) begin
          mA.valid = 0;
        end
        mB = nB;
        if (hold) stallCnt++;
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    applyStimulus(s);
    stepClock();
  endtask

  task automatic doReset();
    stim_t s;
    s       = idle();
    s.reset = 1'b1;
    cycle(s);
  endtask

  initial begin
    stim_t s;
    mA = '{valid: 0, instr: 0, pc: 0, imm: 0, rs1: 0, rs2: 0, rd: 0};
    mB = mA;
    for (int i = 0; i < 32; i++) rfMem[i] = $urandom;
    rfMem[1] = 32'h11;
    rfMem[2] = 32'h22;
    rfMem[3] = 32'h5;

    doReset();
    applyStimulus(idle());
    checkOutput("rst_ready", 32'(dec_ready), 32'd1);
    checkOutput("rst_ex_instr", ex_instr, NOP);
    stepClock();

    // Three independent back-to-back instructions with RF operands.
    for (int i = 0; i < 6; i++) begin
      s = (i < 3) ? instrStim(32'h100 + 32'(i), 5'd1, 5'd2, 5'(5 + i), 1'b1, 1'b1) : idle();
      applyStimulus(s);
      if (i >= 2 && i <= 4) begin
        checkOutput("ind_valid", 32'(ex_valid), 32'd1);
        checkOutput("ind_rs1", ex_rs1_val, 32'h11);
        checkOutput("ind_rs2", ex_rs2_val, 32'h22);
      end
      stepClock();
    end

    cycle(instrStim(32'h200, 5'd3, 5'd2, 5'd9, 1'b1, 1'b1));
    cycle(idle());
    s          = idle();
    s.fe1      = 1'b1;
    s.fd1      = 32'hDEADBEEF;
    applyStimulus(s);
    checkOutput("fwd_rs1", ex_rs1_val, 32'hDEADBEEF);
    checkOutput("fwd_rs2_rf", ex_rs2_val, 32'h22);
    stepClock();

    cycle(instrStim(32'h300, 5'd0, 5'd7, 5'd4, 1'b1, 1'b0));
    applyStimulus(idle());
    checkOutput("unused_of_rs2", 32'(of_rs2), 32'd0);
    stepClock();
    s     = idle();
    s.fe1 = 1'b1;
    s.fd1 = 32'h1234;
    applyStimulus(s);
    checkOutput("x0_rs1", ex_rs1_val, 32'd0);
    stepClock();

    // Two-cycle stall on a held instruction, then a single issue.
    doReset();
    cycle(instrStim(32'h400, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    s       = instrStim(32'h401, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
    s.stall = 1'b1;
    applyStimulus(s);
    checkOutput("stall_ready", 32'(dec_ready), 32'd0);
    stepClock();
    s        = idle();
    s.stall  = 1'b1;
    applyStimulus(s);
    checkOutput("stall_bubble", ex_instr, NOP);
    stepClock();
    applyStimulus(idle());
    checkOutput("stall_cnt2", 32'(stall_count), 32'd2);
    checkOutput("stall_held", 32'(of_valid), 32'd1);
    checkOutput("stall_bubble2", 32'(ex_valid), 32'd0);
    stepClock();
    applyStimulus(idle());
    checkOutput("stall_issue", ex_instr, 32'h400);
    stepClock();
    applyStimulus(idle());
    checkOutput("stall_once", 32'(ex_valid), 32'd0);
    stepClock();

    // Flush with stall and decode valid at the same time.
    cycle(instrStim(32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    cycle(instrStim(32'h501, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    s       = instrStim(32'h502, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    s.flush = 1'b1;
    s.stall = 1'b1;
    cycle(s);
    applyStimulus(idle());
    checkOutput("flush_a", 32'(of_valid), 32'd0);
    checkOutput("flush_b", 32'(ex_valid), 32'd0);
    checkOutput("flush_cnt", 32'(stall_count), 32'd2);
    stepClock();

    cycle(instrStim(32'h600, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    for (int i = 0; i < 20; i++) begin
      s       = idle();
      s.stall = 1'b1;
      cycle(s);
    end
    applyStimulus(idle());
    checkOutput("sat_cnt4", 32'(stall_count4), 32'd15);
    checkOutput("sat_cnt16", 32'(stall_count), 32'd22);
    stepClock();

    // Reset arriving while the pipeline is full.
    cycle(instrStim(32'h700, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    cycle(instrStim(32'h701, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
    s       = instrStim(32'h702, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    s.reset = 1'b1;
    cycle(s);
    applyStimulus(idle());
    checkOutput("mid_rst_a", 32'(of_valid), 32'd0);
    checkOutput("mid_rst_b", 32'(ex_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(stall_count), 32'd0);
    stepClock();

    for (int i = 0; i < 600; i++) cycle(randStim());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
